mainfsm: RTL

- Moore control FSM for the multicycle ARM core.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and the write enables. Its regw output, after condition gating, becomes the register file's we3.
- Sits between the instruction decoder (which supplies op/funct) and the datapath.

---
 rtl/arm_ctrl_pkg.sv | 67 ++++++
 rtl/mainfsm_outdec.sv | 77 +++++++
 rtl/mainfsm.sv | 94 +++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_ctrl_pkg
//  Description : Shared encodings for the multicycle ARM control path:
//                FSM state codes, mux select codes, opcode classes and the
//                packed control vector produced by the main FSM decode.
//  Revision    : 1.0  initial release
// ============================================================================
package arm_ctrl_pkg;

  localparam int STATE_BITS = 4;

  // State codes are fixed so the debug state output has a stable meaning.
  typedef enum logic [STATE_BITS-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_RD2    = 2'b00;
  localparam logic [1:0] ALUSRCB_EXTIMM = 2'b01;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b10;

  // Result mux select
  localparam logic [1:0] RESULTSRC_ALUOUT = 2'b00;
  localparam logic [1:0] RESULTSRC_MEM    = 2'b01;
  localparam logic [1:0] RESULTSRC_ALURES = 2'b10;

  // Instruction class from bits [27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Full control vector for one state
  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic       illegal;
  } ctrl_t;

  // All-inactive control vector, the starting point of every decode.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage : arm_ctrl_pkg
`default_nettype wire

// File: rtl/mainfsm_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : mainfsm_outdec
//  Description : Purely combinational Moore output decode, state -> control
//                vector. Unused state encodings decode to all-inactive.
//  Revision    : 1.0  initial release
// ============================================================================
module mainfsm_outdec
  import arm_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  // Map each state to the datapath controls it asserts; everything else 0.
  always_comb begin
    ctrl = ctrl_idle();
    case (state)
      FETCH: begin
        ctrl.adrsrc    = 1'b0;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = ALUSRCB_FOUR;
        ctrl.resultsrc = RESULTSRC_ALURES;
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
      end
      // PC+4 again: the value read back as r15 is PC+8.
      DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = ALUSRCB_FOUR;
        ctrl.resultsrc = RESULTSRC_ALURES;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = ALUSRCB_EXTIMM;
      end
      MEMRD: begin
        ctrl.resultsrc = RESULTSRC_ALUOUT;
        ctrl.adrsrc    = 1'b1;
      end
      MEMWR: begin
        ctrl.resultsrc = RESULTSRC_ALUOUT;
        ctrl.adrsrc    = 1'b1;
        ctrl.memw      = 1'b1;
      end
      MEMWB: begin
        ctrl.resultsrc = RESULTSRC_MEM;
        ctrl.regw      = 1'b1;
      end
      EXECUTER: begin
        ctrl.alusrcb = ALUSRCB_RD2;
        ctrl.aluop   = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alusrcb = ALUSRCB_EXTIMM;
        ctrl.aluop   = 1'b1;
      end
      ALUWB: begin
        ctrl.resultsrc = RESULTSRC_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrcb   = ALUSRCB_EXTIMM;
        ctrl.resultsrc = RESULTSRC_ALURES;
        ctrl.branch    = 1'b1;
      end
      UNKNOWN: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        ctrl = ctrl_idle();
      end
    endcase
  end

endmodule : mainfsm_outdec
`default_nettype wire

// File: rtl/mainfsm.sv
`default_nettype none
// ============================================================================
//  Module      : mainfsm
//  Description : Moore main control FSM of the multicycle ARM core. Steps
//                each instruction through fetch/decode/execute/memory/
//                writeback and drives datapath selects and write requests.
//  Revision    : 1.0  initial release
// ============================================================================
module mainfsm
  import arm_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  output logic               irwrite,
  output logic               adrsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         resultsrc,
  output logic               nextpc,
  output logic               regw,
  output logic               memw,
  output logic               branch,
  output logic               aluop,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  // Only I (bit 5) and L (bit 0) steer the sequence.
  logic unused_funct;
  assign unused_funct = ^funct[4:1];

  // State register; reset drops straight to FETCH without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; op/funct matter only in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Selects come straight from the decode (state is already FETCH while
  // reset is high); enables and the illegal pulse are held off during reset.
  always_comb begin
    adrsrc    = ctrl.adrsrc;
    alusrca   = ctrl.alusrca;
    alusrcb   = ctrl.alusrcb;
    resultsrc = ctrl.resultsrc;
    aluop     = ctrl.aluop;
    irwrite   = ctrl.irwrite & ~reset;
    nextpc    = ctrl.nextpc  & ~reset;
    regw      = ctrl.regw    & ~reset;
    memw      = ctrl.memw    & ~reset;
    branch    = ctrl.branch  & ~reset;
    illegal   = ctrl.illegal & ~reset;
  end

  assign state = STATE_W'(state_q);

endmodule : mainfsm
`default_nettype wire
